acc_offload_issue: RTL and testbench
====================================

Name: acc_offload_issue

Overview:
- Issue stage between the core's offload port and the accelerator request channel.
- Matches each offered instruction against a compile-time table of acc_pkg::offl_instr_t entries and rejects instructions that do not match.
- For matched instructions: builds operands A/B/C from register values or decoded immediates, tracks pending destination registers in a scoreboard, and issues through a registered valid/ready output stage.

Parameters:
- NumInstr, 1, number of table entries (>=1).
- OfflInstr, all-zero array [NumInstr], offl_instr_t table (instr_data/instr_mask/writeback/use_rs/op_*_mux/imm_*_mux).
- MaxOutstanding, 4, maximum issued-but-unanswered writeback instructions (>=1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- x_valid_i  in  1  core offers an instruction.
- x_ready_o  out  1  handshake completes this cycle.
- x_instr_i  in  32  instruction word.
- x_rs_i  in  3x32  rs1..rs3 values.
- x_rs_valid_i  in  3  per-operand valid.
- x_accept_o  out  1  qualifies x_ready_o: 1 = offloaded, 0 = rejected.
- acc_req_valid_o  out  1  request valid.
- acc_req_ready_i  in  1  accelerator accepts the request.
- acc_req_instr_o  out  32  issued instruction word.
- acc_req_op_o  out  3x32  operands A, B, C.
- rsp_valid_i  in  1  writeback response.
- rsp_rd_i  in  5  register answered by the response.

Behaviour:
- Reset (async assert, sync release):
  - acc_req_valid_o=0; acc_req_instr_o and acc_req_op_o = 0.
  - Scoreboard busy[31:0]=0; outstanding counter=0.
- Match:
  - Entry i matches when (x_instr_i & instr_mask) == instr_data.
  - If several entries match, the lowest index wins.
  - Matching is combinational in the offer cycle.
- No match: x_ready_o=1 and x_accept_o=0 in the same cycle as x_valid_i. No state change.
- Match: x_accept_o=1. x_ready_o=1 only when all of the following hold:
  - (a) x_rs_valid_i[k] for every use_rs[k]=1.
  - (b) busy[rsN] is clear for every used rsN (rs1=instr[19:15], rs2=[24:20], rs3=[31:27]).
  - (c) If writeback!=0: busy[rd] is clear (rd=[11:7]) and the counter is < MaxOutstanding.
  - (d) The output stage is empty, or acc_req_ready_i=1 in this cycle.
- Otherwise x_ready_o=0, the core holds its inputs, and nothing changes.
- Hazard checks use the registered busy vector. A response clearing busy[r] in cycle t unblocks an instruction only from cycle t+1 (no bypass).
- Operand per slot:
  - op_x_mux=OP_RS selects the slot's register (A=rs1, B=rs2, C=rs3).
  - op_x_mux=OP_IMM selects the immediate given by imm_x_mux. All immediates are sign-extended to 32 bit:
    - IMM_I = instr[31:20].
    - IMM_S = {instr[31:25], instr[11:7]}.
    - IMM_B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
    - IMM_U = {instr[31:12], 12'b0}.
    - IMM_J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Unused op_sel code 2/3 or imm_sel code 5..7 yields 0.
- Output stage: one register.
  - An accepted matched instruction loads instr and operands on the handshake edge. acc_req_valid_o rises the next cycle (latency 1).
  - Once valid, instr and op stay stable until acc_req_ready_i=1.
  - Simultaneous drain and load keeps valid=1 with the new contents (back-to-back issue, one per cycle).
- Scoreboard: on acceptance with writeback!=0:
  - busy[rd] is set, except rd=0, which is never set.
  - The counter increments.
- On rsp_valid_i:
  - busy[rsp_rd_i] is cleared.
  - The counter decrements, saturating at 0.
- Simultaneous increment and decrement leave the counter unchanged. Set and clear of the same rd cannot coincide, because of check (c).
- An unsolicited response (counter=0) clears the busy bit only.
- Reset mid-operation drops the pending request and all scoreboard state immediately.

Test Plan:
- Table entry0 = {data=0x0000000B, mask=0x0000007F, writeback=1, use_rs=3'b011, A=B=OP_RS}. Offer 0x00B5850B with rs1=0x11, rs2=0x22 -> same-cycle ready=1, accept=1; next cycle acc_req_valid=1, op A=0x11, B=0x22; busy[10]=1.
- Offer 0x00000033 (no match) -> ready=1, accept=0 in the offer cycle, acc_req_valid stays 0.
- After test 1, offer a matching instruction with rs1=x10 -> ready=0 until rsp_valid_i with rd=10. Ready rises in the cycle after the response, and the request then issues.
- Entry with op_c=OP_IMM, imm_c=IMM_I, instruction 0xFFF0050B -> op C=0xFFFFFFFF. With IMM_U and instruction 0x12345..., op C=0x12345000.
- Hold acc_req_ready_i=0 for 3 cycles -> acc_req_valid_o=1 and contents stable, x_ready_o=0. Release ready -> drain and reload in the same cycle, with a new request valid the next cycle.
- With MaxOutstanding=2, issue writebacks to rd=5 and rd=6 -> the third writeback is stalled. Assert rst_i mid-stall -> acc_req_valid=0, busy=0, counter=0 asynchronously.

Source files
------------

// File: rtl/acc_offload_issue.sv
// acc_offload_issue: issue stage from the core offload port to the accelerator
// request channel. Table-driven match, operand build, scoreboard, output reg.
//
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   x_valid_i/x_ready_o   offer handshake; x_accept_o = offloaded (1) / rejected (0)
//   x_instr_i, x_rs_i     instruction word and rs1..rs3 values
//   x_rs_valid_i          per-operand valid
//   acc_req_*             registered request: valid/ready, instr, operands A/B/C
//   rsp_valid_i, rsp_rd_i writeback response releasing a destination register

package acc_pkg;
    typedef logic [1:0] op_sel_t;
    typedef logic [2:0] imm_sel_t;

    localparam op_sel_t OP_RS  = 2'd0;
    localparam op_sel_t OP_IMM = 2'd1;

    localparam imm_sel_t IMM_I = 3'd0;
    localparam imm_sel_t IMM_S = 3'd1;
    localparam imm_sel_t IMM_B = 3'd2;
    localparam imm_sel_t IMM_U = 3'd3;
    localparam imm_sel_t IMM_J = 3'd4;

    typedef struct packed {
        logic [31:0] instr_data;
        logic [31:0] instr_mask;
        logic        writeback;
        logic [2:0]  use_rs;
        op_sel_t     op_a_mux;
        op_sel_t     op_b_mux;
        op_sel_t     op_c_mux;
        imm_sel_t    imm_a_mux;
        imm_sel_t    imm_b_mux;
        imm_sel_t    imm_c_mux;
    } offl_instr_t;
endpackage

module acc_offload_issue
    import acc_pkg::*;
#(
    parameter int unsigned NumInstr = 1,
    parameter offl_instr_t [NumInstr-1:0] OfflInstr = '0,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             x_valid_i,
    output logic             x_ready_o,
    input  logic [31:0]      x_instr_i,
    input  logic [2:0][31:0] x_rs_i,
    input  logic [2:0]       x_rs_valid_i,
    output logic             x_accept_o,
    output logic             acc_req_valid_o,
    input  logic             acc_req_ready_i,
    output logic [31:0]      acc_req_instr_o,
    output logic [2:0][31:0] acc_req_op_o,
    input  logic             rsp_valid_i,
    input  logic [4:0]       rsp_rd_i
);

    localparam int CW = $clog2(MaxOutstanding + 1);

    logic [31:0]      busy;
    logic [CW-1:0]    cnt;
    logic             hit;
    offl_instr_t      ent;
    logic [2:0][4:0]  rs;
    logic [4:0]       rd;
    logic             rs_ok;
    logic             wb_ok;
    logic             out_ok;
    logic             issue;
    logic             alloc;
    logic [2:0][31:0] op_next;

    function automatic logic [31:0] imm_val(input imm_sel_t s,
                                            input logic [31:0] i);
        logic [31:0] v;
        v = '0;
        case (s)
            IMM_I: v = {{20{i[31]}}, i[31:20]};
            IMM_S: v = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B: v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U: v = {i[31:12], 12'b0};
            IMM_J: v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] operand(input op_sel_t m,
                                            input imm_sel_t s,
                                            input logic [31:0] r,
                                            input logic [31:0] i);
        logic [31:0] v;
        v = '0;
        case (m)
            OP_RS:   v = r;
            OP_IMM:  v = imm_val(s, i);
            default: v = '0;
        endcase
        return v;
    endfunction

    // Scan downwards so the lowest matching index is the one left in ent.
    always_comb begin
        hit = 1'b0;
        ent = '0;
        for (int i = int'(NumInstr) - 1; i >= 0; i--) begin
            if ((x_instr_i & OfflInstr[i].instr_mask) == OfflInstr[i].instr_data) begin
                hit = 1'b1;
                ent = OfflInstr[i];
            end
        end
    end

    assign rs[0] = x_instr_i[19:15];
    assign rs[1] = x_instr_i[24:20];
    assign rs[2] = x_instr_i[31:27];
    assign rd    = x_instr_i[11:7];

    always_comb begin
        rs_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (ent.use_rs[k] && (!x_rs_valid_i[k] || busy[rs[k]])) begin
                rs_ok = 1'b0;
            end
        end
    end

    assign wb_ok  = !ent.writeback || (!busy[rd] && (cnt < CW'(MaxOutstanding)));
    assign out_ok = !acc_req_valid_o || acc_req_ready_i;
    assign issue  = x_valid_i && hit && rs_ok && wb_ok && out_ok;
    assign alloc  = issue && ent.writeback;

    assign x_accept_o = hit;
    assign x_ready_o  = x_valid_i && (!hit || (rs_ok && wb_ok && out_ok));

    assign op_next[0] = operand(ent.op_a_mux, ent.imm_a_mux, x_rs_i[0], x_instr_i);
    assign op_next[1] = operand(ent.op_b_mux, ent.imm_b_mux, x_rs_i[1], x_instr_i);
    assign op_next[2] = operand(ent.op_c_mux, ent.imm_c_mux, x_rs_i[2], x_instr_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_req_valid_o <= 1'b0;
            acc_req_instr_o <= '0;
            acc_req_op_o    <= '0;
        end else if (issue) begin
            acc_req_valid_o <= 1'b1;
            acc_req_instr_o <= x_instr_i;
            acc_req_op_o    <= op_next;
        end else if (acc_req_ready_i) begin
            acc_req_valid_o <= 1'b0;
        end
    end

    // x0 is never tracked; a response arriving with no issue pending
    // only clears its busy bit and leaves the counter at zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy <= '0;
            cnt  <= '0;
        end else begin
            if (rsp_valid_i) begin
                busy[rsp_rd_i] <= 1'b0;
            end
            if (alloc && (rd != 5'd0)) begin
                busy[rd] <= 1'b1;
            end
            if (alloc && !rsp_valid_i) begin
                cnt <= cnt + CW'(1);
            end else if (!alloc && rsp_valid_i && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_acc_offload_issue.sv
// tb_acc_offload_issue: directed scenarios plus a randomized run checked
// against a behavioural model of the issue stage.

module tb_acc_offload_issue;
    import acc_pkg::*;

    localparam int NI   = 4;
    localparam int MAXO = 2;

    typedef offl_instr_t [NI-1:0] tbl_t;

    function automatic tbl_t mk_table();
        tbl_t t;
        t[0] = '{instr_data: 32'h0000000B, instr_mask: 32'h0000007F,
                 writeback: 1'b1, use_rs: 3'b011,
                 op_a_mux: OP_RS, op_b_mux: OP_RS, op_c_mux: OP_RS,
                 imm_a_mux: IMM_I, imm_b_mux: IMM_I, imm_c_mux: IMM_I};
        t[1] = '{instr_data: 32'h0000002B, instr_mask: 32'h0000707F,
                 writeback: 1'b0, use_rs: 3'b001,
                 op_a_mux: OP_RS, op_b_mux: OP_IMM, op_c_mux: OP_IMM,
                 imm_a_mux: IMM_I, imm_b_mux: IMM_S, imm_c_mux: IMM_I};
        t[2] = '{instr_data: 32'h0000502B, instr_mask: 32'h0000707F,
                 writeback: 1'b0, use_rs: 3'b000,
                 op_a_mux: OP_IMM, op_b_mux: OP_IMM, op_c_mux: OP_IMM,
                 imm_a_mux: IMM_B, imm_b_mux: IMM_J, imm_c_mux: IMM_U};
        t[3] = '{instr_data: 32'h0000002B, instr_mask: 32'h0000007F,
                 writeback: 1'b0, use_rs: 3'b100,
                 op_a_mux: 2'd2, op_b_mux: OP_IMM, op_c_mux: OP_RS,
                 imm_a_mux: IMM_I, imm_b_mux: 3'd5, imm_c_mux: IMM_I};
        return t;
    endfunction

    localparam tbl_t TBL = mk_table();

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             x_valid_i;
    logic             x_ready_o;
    logic [31:0]      x_instr_i;
    logic [2:0][31:0] x_rs_i;
    logic [2:0]       x_rs_valid_i;
    logic             x_accept_o;
    logic             acc_req_valid_o;
    logic             acc_req_ready_i;
    logic [31:0]      acc_req_instr_o;
    logic [2:0][31:0] acc_req_op_o;
    logic             rsp_valid_i;
    logic [4:0]       rsp_rd_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    acc_offload_issue #(
        .NumInstr(NI),
        .OfflInstr(TBL),
        .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .x_valid_i(x_valid_i),
        .x_ready_o(x_ready_o),
        .x_instr_i(x_instr_i),
        .x_rs_i(x_rs_i),
        .x_rs_valid_i(x_rs_valid_i),
        .x_accept_o(x_accept_o),
        .acc_req_valid_o(acc_req_valid_o),
        .acc_req_ready_i(acc_req_ready_i),
        .acc_req_instr_o(acc_req_instr_o),
        .acc_req_op_o(acc_req_op_o),
        .rsp_valid_i(rsp_valid_i),
        .rsp_rd_i(rsp_rd_i)
    );

    task automatic idle();
        x_valid_i       = 1'b0;
        x_instr_i       = '0;
        x_rs_i          = '0;
        x_rs_valid_i    = '0;
        acc_req_ready_i = 1'b1;
        rsp_valid_i     = 1'b0;
        rsp_rd_i        = '0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference model helpers, written from the encoding rules.
    function automatic int m_match(input logic [31:0] w);
        for (int i = 0; i < NI; i++) begin
            if ((w & TBL[i].instr_mask) == TBL[i].instr_data) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] m_imm(input int s, input logic [31:0] i);
        int v;
        case (s)
            0: v = $signed(i) >>> 20;
            1: v = (($signed(i) >>> 25) <<< 5) | int'(i[11:7]);
            2: v = (($signed(i) >>> 31) <<< 12) | (int'(i[7]) << 11)
                   | (int'(i[30:25]) << 5) | (int'(i[11:8]) << 1);
            3: v = i & 32'hFFFFF000;
            4: v = (($signed(i) >>> 31) <<< 20) | (int'(i[19:12]) << 12)
                   | (int'(i[20]) << 11) | (int'(i[30:21]) << 1);
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] m_op(input int e, input int k,
                                         input logic [31:0] w,
                                         input logic [31:0] r);
        int m;
        int s;
        m = (k == 0) ? int'(TBL[e].op_a_mux) :
            (k == 1) ? int'(TBL[e].op_b_mux) : int'(TBL[e].op_c_mux);
        s = (k == 0) ? int'(TBL[e].imm_a_mux) :
            (k == 1) ? int'(TBL[e].imm_b_mux) : int'(TBL[e].imm_c_mux);
        if (m == 0) return r;
        if (m == 1) return m_imm(s, w);
        return 32'h0;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(4))
            0, 1: begin
                w[6:0]   = 7'h0B;
                w[11:7]  = 5'($urandom_range(7));
                w[19:15] = 5'($urandom_range(7));
                w[24:20] = 5'($urandom_range(7));
            end
            2: begin
                w[6:0]   = 7'h2B;
                w[19:15] = 5'($urandom_range(7));
                w[31:27] = 5'($urandom_range(7));
            end
            3: w[6:0] = 7'h33;
            default: ;
        endcase
        return w;
    endfunction

    task automatic test_reset();
        rst_i = 1'b1;
        idle();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_tests++;
        if (acc_req_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", acc_req_valid_o);
        end
        n_tests++;
        if (acc_req_instr_o !== 32'h0 || acc_req_op_o !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h expected 0", acc_req_instr_o, acc_req_op_o);
        end
        n_tests++;
        if (dut.busy !== 32'h0 || dut.cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_sb: got busy %h cnt %0d expected 0/0", dut.busy, dut.cnt);
        end
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_match_issue();
        x_valid_i    = 1'b1;
        x_instr_i    = 32'h00B5850B;
        x_rs_i[0]    = 32'h11;
        x_rs_i[1]    = 32'h22;
        x_rs_valid_i = 3'b011;
        @(negedge clk_i);
        n_tests++;
        if (x_ready_o !== 1'b1 || x_accept_o !== 1'b1) begin
            n_fail++;
            $display("FAIL match_hs: got ready %b accept %b expected 1 1", x_ready_o, x_accept_o);
        end
        tick();
        x_valid_i = 1'b0;
        @(negedge clk_i);
        n_tests++;
        if (acc_req_valid_o !== 1'b1 || acc_req_instr_o !== 32'h00B5850B) begin
            n_fail++;
            $display("FAIL match_req: got %b %h expected 1 00b5850b", acc_req_valid_o, acc_req_instr_o);
        end
        n_tests++;
        if (acc_req_op_o[0] !== 32'h11 || acc_req_op_o[1] !== 32'h22) begin
            n_fail++;
            $display("FAIL match_ops: got %h %h expected 11 22", acc_req_op_o[0], acc_req_op_o[1]);
        end
        n_tests++;
        if (dut.busy[10] !== 1'b1) begin
            n_fail++;
            $display("FAIL match_busy: got %b expected 1", dut.busy[10]);
        end
    endtask

    task automatic test_no_match();
        tick();
        x_valid_i = 1'b1;
        x_instr_i = 32'h00000033;
        @(negedge clk_i);
        n_tests++;
        if (x_ready_o !== 1'b1 || x_accept_o !== 1'b0) begin
            n_fail++;
            $display("FAIL nomatch_hs: got ready %b accept %b expected 1 0", x_ready_o, x_accept_o);
        end
        tick();
        x_valid_i = 1'b0;
        @(negedge clk_i);
        n_tests++;
        if (acc_req_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL nomatch_valid: got %b expected 0", acc_req_valid_o);
        end
    endtask

    task automatic test_hazard();
        tick();
        x_valid_i    = 1'b1;
        x_instr_i    = 32'h0005060B;
        x_rs_i       = '0;
        x_rs_valid_i = 3'b011;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            n_tests++;
            if (x_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL hazard_stall%0d: got %b expected 0", i, x_ready_o);
            end
            tick();
        end
        rsp_valid_i = 1'b1;
        rsp_rd_i    = 5'd10;
        @(negedge clk_i);
        n_tests++;
        if (x_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_nobypass: got %b expected 0", x_ready_o);
        end
        tick();
        rsp_valid_i = 1'b0;
        @(negedge clk_i);
        n_tests++;
        if (x_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL hazard_release: got %b expected 1", x_ready_o);
        end
        tick();
        x_valid_i = 1'b0;
        @(negedge clk_i);
        n_tests++;
        if (acc_req_valid_o !== 1'b1 || acc_req_instr_o !== 32'h0005060B) begin
            n_fail++;
            $display("FAIL hazard_issue: got %b %h expected 1 0005060b", acc_req_valid_o, acc_req_instr_o);
        end
        tick();
        rsp_valid_i = 1'b1;
        rsp_rd_i    = 5'd12;
        tick();
        rsp_valid_i = 1'b0;
    endtask

    task automatic test_imm();
        x_valid_i    = 1'b1;
        x_instr_i    = 32'hFFF0052B;
        x_rs_i[0]    = 32'hA5A5A5A5;
        x_rs_valid_i = 3'b001;
        @(negedge clk_i);
        n_tests++;
        if (x_ready_o !== 1'b1 || x_accept_o !== 1'b1) begin
            n_fail++;
            $display("FAIL imm_hs: got ready %b accept %b expected 1 1", x_ready_o, x_accept_o);
        end
        tick();
        x_instr_i    = 32'h1234552B;
        x_rs_valid_i = 3'b000;
        @(negedge clk_i);
        n_tests++;
        if (acc_req_op_o !== {32'hFFFFFFFF, 32'hFFFFFFEA, 32'hA5A5A5A5}) begin
            n_fail++;
            $display("FAIL imm_i_s: got %h expected ffffffff_ffffffea_a5a5a5a5", acc_req_op_o);
        end
        n_tests++;
        if (x_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL imm_b2b: got %b expected 1", x_ready_o);
        end
        tick();
        x_instr_i    = 32'h2800202B;
        x_rs_i[2]    = 32'hC0FFEE00;
        x_rs_valid_i = 3'b100;
        @(negedge clk_i);
        n_tests++;
        if (acc_req_op_o !== {32'h12345000, 32'h00045922, 32'h0000012A}) begin
            n_fail++;
            $display("FAIL imm_u_j_b: got %h expected 12345000_00045922_0000012a", acc_req_op_o);
        end
        tick();
        x_valid_i = 1'b0;
        @(negedge clk_i);
        n_tests++;
        if (acc_req_op_o !== {32'hC0FFEE00, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL imm_unused_sel: got %h expected c0ffee00_0_0", acc_req_op_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        acc_req_ready_i = 1'b0;
        x_valid_i       = 1'b1;
        x_instr_i       = 32'h0000802B;
        x_rs_i[0]       = 32'h111;
        x_rs_valid_i    = 3'b001;
        tick();
        x_instr_i = 32'h0001002B;
        x_rs_i[0] = 32'h222;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            n_tests++;
            if (x_ready_o !== 1'b0 || acc_req_valid_o !== 1'b1 ||
                acc_req_instr_o !== 32'h0000802B || acc_req_op_o[0] !== 32'h111) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got rdy %b vld %b %h %h expected 0 1 0000802b 111",
                         i, x_ready_o, acc_req_valid_o, acc_req_instr_o, acc_req_op_o[0]);
            end
            tick();
        end
        acc_req_ready_i = 1'b1;
        @(negedge clk_i);
        n_tests++;
        if (x_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got %b expected 1", x_ready_o);
        end
        tick();
        x_valid_i = 1'b0;
        @(negedge clk_i);
        n_tests++;
        if (acc_req_valid_o !== 1'b1 || acc_req_instr_o !== 32'h0001002B ||
            acc_req_op_o[0] !== 32'h222) begin
            n_fail++;
            $display("FAIL bp_reload: got %b %h %h expected 1 0001002b 222",
                     acc_req_valid_o, acc_req_instr_o, acc_req_op_o[0]);
        end
        tick();
    endtask

    task automatic test_max_outstanding();
        x_valid_i    = 1'b1;
        x_rs_i       = '0;
        x_rs_valid_i = 3'b011;
        x_instr_i    = 32'h0000028B;
        @(negedge clk_i);
        n_tests++;
        if (x_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL maxo_rd5: got %b expected 1", x_ready_o);
        end
        tick();
        x_instr_i = 32'h0000030B;
        @(negedge clk_i);
        n_tests++;
        if (x_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL maxo_rd6: got %b expected 1", x_ready_o);
        end
        tick();
        x_instr_i = 32'h0000038B;
        @(negedge clk_i);
        n_tests++;
        if (x_ready_o !== 1'b0 || dut.cnt !== 2 || dut.busy !== 32'h60) begin
            n_fail++;
            $display("FAIL maxo_stall: got rdy %b cnt %0d busy %h expected 0 2 00000060",
                     x_ready_o, dut.cnt, dut.busy);
        end
        #2;
        rst_i = 1'b1;
        #1;
        n_tests++;
        if (acc_req_valid_o !== 1'b0 || dut.busy !== 32'h0 || dut.cnt !== '0) begin
            n_fail++;
            $display("FAIL maxo_async_rst: got vld %b busy %h cnt %0d expected 0 0 0",
                     acc_req_valid_o, dut.busy, dut.cnt);
        end
        idle();
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [31:0]      bsy;
        int               pend[$];
        bit               full;
        logic [31:0]      qi;
        logic [2:0][31:0] qo;
        bit               hold;
        bit               er;
        bit               iss;
        int               ridx;
        int               e;
        logic [4:0]       rs[3];
        logic [4:0]       rd;
        rst_i = 1'b1;
        idle();
        tick();
        rst_i = 1'b0;
        bsy  = '0;
        full = 1'b0;
        qi   = '0;
        qo   = '0;
        hold = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!hold) begin
                x_valid_i = ($urandom_range(3) != 0);
                x_instr_i = gen_instr();
                for (int k = 0; k < 3; k++) x_rs_i[k] = $urandom;
                x_rs_valid_i = 3'($urandom) | 3'($urandom);
            end else begin
                x_rs_valid_i = x_rs_valid_i | 3'($urandom);
            end
            acc_req_ready_i = ($urandom_range(3) != 0);
            ridx        = -1;
            rsp_valid_i = 1'b0;
            rsp_rd_i    = 5'($urandom);
            if (pend.size() > 0 && $urandom_range(2) == 0) begin
                ridx        = $urandom_range(pend.size() - 1);
                rsp_valid_i = 1'b1;
                rsp_rd_i    = 5'(pend[ridx]);
            end
            @(negedge clk_i);
            e     = m_match(x_instr_i);
            rs[0] = x_instr_i[19:15];
            rs[1] = x_instr_i[24:20];
            rs[2] = x_instr_i[31:27];
            rd    = x_instr_i[11:7];
            er    = 1'b1;
            if (e >= 0) begin
                for (int k = 0; k < 3; k++) begin
                    if (TBL[e].use_rs[k] && (!x_rs_valid_i[k] || bsy[rs[k]])) er = 1'b0;
                end
                if (TBL[e].writeback && (bsy[rd] || pend.size() >= MAXO)) er = 1'b0;
                if (full && !acc_req_ready_i) er = 1'b0;
            end
            iss = x_valid_i && (e >= 0) && er;
            if (x_valid_i) begin
                n_tests++;
                if (x_ready_o !== er || x_accept_o !== (e >= 0)) begin
                    n_fail++;
                    $display("FAIL rand_hs@%0d: instr %h got rdy %b acc %b expected %b %b",
                             n, x_instr_i, x_ready_o, x_accept_o, er, (e >= 0));
                end
            end
            n_tests++;
            if (acc_req_valid_o !== full ||
                (full && (acc_req_instr_o !== qi || acc_req_op_o !== qo))) begin
                n_fail++;
                $display("FAIL rand_req@%0d: got %b %h %h expected %b %h %h",
                         n, acc_req_valid_o, acc_req_instr_o, acc_req_op_o, full, qi, qo);
            end
            @(posedge clk_i);
            if (ridx >= 0) begin
                bsy[pend[ridx]] = 1'b0;
                pend.delete(ridx);
            end
            if (iss) begin
                if (TBL[e].writeback) begin
                    if (rd != 5'd0) bsy[rd] = 1'b1;
                    pend.push_back(int'(rd));
                end
                full = 1'b1;
                qi   = x_instr_i;
                for (int k = 0; k < 3; k++) qo[k] = m_op(e, k, x_instr_i, x_rs_i[k]);
            end else if (acc_req_ready_i) begin
                full = 1'b0;
            end
            #1;
            hold = x_valid_i && !er;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_match_issue();
        test_no_match();
        test_hazard();
        test_imm();
        test_back_to_back();
        test_max_outstanding();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
